// File: rtl/jstk_dir_filter.sv
// Joystick direction filter: classifies each X/Y sample into a direction, debounces it,
// latches it with hysteresis around the dead zone and optionally auto-repeats a held move.
module jstk_dir_filter #(
  parameter int WIDTH          = 10,
  parameter int CENTER_LO      = 384,
  parameter int CENTER_HI      = 640,
  parameter int HYST           = 32,
  parameter int STABLE_CNT     = 3,
  parameter int REPEAT_SAMPLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] x_pos,
  input  logic [WIDTH-1:0] y_pos,
  output logic [2:0]       dir,
  output logic             move_pulse,
  output logic             busy
);

  localparam logic [2:0] DIR_UP    = 3'd0;
  localparam logic [2:0] DIR_DOWN  = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_NONE  = 3'd4;

  localparam logic [WIDTH-1:0] LO_V     = WIDTH'(CENTER_LO);
  localparam logic [WIDTH-1:0] HI_V     = WIDTH'(CENTER_HI);
  localparam logic [WIDTH-1:0] REL_LO_V = WIDTH'(CENTER_LO + HYST);
  localparam logic [WIDTH-1:0] REL_HI_V = WIDTH'(CENTER_HI - HYST);

  localparam logic [3:0] STABLE_V = 4'(STABLE_CNT);

  // One spare count value so the saturating increment can never wrap.
  localparam int            RW        = (REPEAT_SAMPLES > 0) ? $clog2(REPEAT_SAMPLES + 2) : 1;
  localparam logic [RW-1:0] REPEAT_V  = RW'(REPEAT_SAMPLES);
  localparam bit            REPEAT_EN = (REPEAT_SAMPLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  logic [WIDTH-1:0] axis_pos [2];
  logic [1:0]       is_low;
  logic [1:0]       is_high;
  logic [1:0]       is_mid;
  logic [1:0]       in_release;
  logic [2:0]       raw_dir;

  state_t        state_q, state_d;
  logic [2:0]    cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [2:0]    dir_q, dir_d;
  logic          pulse_q, pulse_d;

  logic [3:0]    cnt_inc;
  logic [RW-1:0] rep_inc;
  logic          enter_held;
  logic [2:0]    held_dir;
  logic          go_idle;

  assign axis_pos[0] = x_pos;
  assign axis_pos[1] = y_pos;

  // Index 0 is X, index 1 is Y.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      assign is_low[gi]     = (axis_pos[gi] < LO_V);
      assign is_high[gi]    = (axis_pos[gi] > HI_V);
      assign is_mid[gi]     = !is_low[gi] && !is_high[gi];
      assign in_release[gi] = (axis_pos[gi] >= REL_LO_V) && (axis_pos[gi] <= REL_HI_V);
    end
  endgenerate

  always_comb begin
    raw_dir = DIR_NONE;
    if (is_mid[0] && is_high[1]) begin
      raw_dir = DIR_UP;
    end else if (is_mid[0] && is_low[1]) begin
      raw_dir = DIR_DOWN;
    end else if (is_mid[1] && is_high[0]) begin
      raw_dir = DIR_RIGHT;
    end else if (is_mid[1] && is_low[0]) begin
      raw_dir = DIR_LEFT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cand_q  <= DIR_NONE;
      cnt_q   <= '0;
      rep_q   <= '0;
      dir_q   <= DIR_NONE;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    dir_d      = dir_q;
    pulse_d    = 1'b0;
    enter_held = 1'b0;
    held_dir   = cand_q;
    go_idle    = 1'b0;
    cnt_inc    = (cnt_q >= STABLE_V) ? cnt_q : cnt_q + 4'd1;
    rep_inc    = (rep_q >= REPEAT_V) ? rep_q : rep_q + RW'(1);

    if (sample_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (raw_dir != DIR_NONE) begin
            cand_d  = raw_dir;
            cnt_d   = 4'd1;
            state_d = ST_ARMED;
            if (STABLE_V <= 4'd1) begin
              enter_held = 1'b1;
              held_dir   = raw_dir;
            end
          end
        end
        ST_ARMED: begin
          if (raw_dir == DIR_NONE) begin
            go_idle = 1'b1;
          end else if (raw_dir == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= STABLE_V) begin
              enter_held = 1'b1;
              held_dir   = cand_q;
            end
          end else begin
            cand_d = raw_dir;
            cnt_d  = 4'd1;
            if (STABLE_V <= 4'd1) begin
              enter_held = 1'b1;
              held_dir   = raw_dir;
            end
          end
        end
        ST_HELD: begin
          if (&in_release) begin
            go_idle = 1'b1;
          end else if (REPEAT_EN && (raw_dir == dir_q)) begin
            if (rep_inc >= REPEAT_V) begin
              // A repeat landing right after a pulse is held back to the next match.
              if (pulse_q) begin
                rep_d = REPEAT_V;
              end else begin
                pulse_d = 1'b1;
                rep_d   = '0;
              end
            end else begin
              rep_d = rep_inc;
            end
          end else begin
            rep_d = '0;
          end
        end
        default: begin
          go_idle = 1'b1;
        end
      endcase

      if (enter_held) begin
        state_d = ST_HELD;
        dir_d   = held_dir;
        pulse_d = 1'b1;
        rep_d   = '0;
      end

      if (go_idle) begin
        state_d = ST_IDLE;
        cand_d  = DIR_NONE;
        cnt_d   = '0;
        rep_d   = '0;
        dir_d   = DIR_NONE;
      end
    end
  end

  assign dir        = dir_q;
  assign move_pulse = pulse_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jstk_dir_filter.sv
// Scoreboard bench for jstk_dir_filter: stimulus pushes model expectations, a monitor
// pops one per sample/reset edge and checks the quiet cycles in between.
module tb_jstk_dir_filter;

  localparam int WIDTH   = 10;
  localparam int C_LO    = 384;
  localparam int C_HI    = 640;
  localparam int HYS     = 32;
  localparam int STABLE  = 3;
  localparam int REPEATN = 4;

  typedef struct {
    logic       pulse;
    logic [2:0] dir;
    logic       busy;
    int         tag;
    int         x;
    int         y;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             sample_valid;
  logic [WIDTH-1:0] x_pos;
  logic [WIDTH-1:0] y_pos;
  logic [2:0]       dir;
  logic             move_pulse;
  logic             busy;

  jstk_dir_filter #(
    .WIDTH(WIDTH), .CENTER_LO(C_LO), .CENTER_HI(C_HI), .HYST(HYS),
    .STABLE_CNT(STABLE), .REPEAT_SAMPLES(REPEATN)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .x_pos(x_pos), .y_pos(y_pos),
    .dir(dir), .move_pulse(move_pulse), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_id = 0;

  // Reference model: run length of identical raw directions while not latched,
  // plus the latched direction and its repeat count.
  int m_run_dir = 4;
  int m_run_len = 0;
  bit m_held    = 1'b0;
  int m_held_dir = 4;
  int m_rep     = 0;

  function automatic int zone_of(input int p);
    if (p < C_LO) return 0;
    if (p > C_HI) return 2;
    return 1;
  endfunction

  function automatic int raw_of(input int x, input int y);
    int zx, zy;
    zx = zone_of(x);
    zy = zone_of(y);
    if (zy == 2 && zx == 1) return 0;
    if (zy == 0 && zx == 1) return 1;
    if (zx == 2 && zy == 1) return 2;
    if (zx == 0 && zy == 1) return 3;
    return 4;
  endfunction

  function automatic bit centered(input int p);
    return (p >= C_LO + HYS) && (p <= C_HI - HYS);
  endfunction

  task automatic model_reset();
    m_run_dir = 4; m_run_len = 0; m_held = 1'b0; m_held_dir = 4; m_rep = 0;
  endtask

  task automatic model_step(input int x, input int y, output exp_t e);
    int raw;
    bit pulse;
    raw = raw_of(x, y);
    pulse = 1'b0;
    if (!m_held) begin
      if (raw == 4) begin
        m_run_len = 0;
      end else if (raw == m_run_dir && m_run_len > 0) begin
        m_run_len++;
      end else begin
        m_run_dir = raw;
        m_run_len = 1;
      end
      if (m_run_len >= STABLE) begin
        m_held = 1'b1; m_held_dir = m_run_dir; m_rep = 0; m_run_len = 0; pulse = 1'b1;
      end
    end else begin
      if (centered(x) && centered(y)) begin
        m_held = 1'b0; m_held_dir = 4; m_rep = 0; m_run_len = 0;
      end else if (REPEATN > 0 && raw == m_held_dir) begin
        m_rep++;
        if (m_rep == REPEATN) begin
          pulse = 1'b1; m_rep = 0;
        end
      end else begin
        m_rep = 0;
      end
    end
    e.pulse = pulse;
    e.dir   = 3'(m_held ? m_held_dir : 4);
    e.busy  = m_held || (m_run_len > 0);
  endtask

  task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s txn=%0d actual=%0d required=%0d t=%0t", name, tag, act, req, $time);
    end
  endtask

  // Monitor
  logic       mon_ev;
  logic [2:0] last_dir   = 3'd4;
  logic       last_busy  = 1'b0;
  logic       prev_pulse = 1'b0;
  exp_t       mon_e;

  always @(posedge clk) begin
    mon_ev = sample_valid || rst;
    #1;
    if (mon_ev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", -1, 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn %0d in=(%0d,%0d) dir=%0d pulse=%0d busy=%0d", mon_e.tag, mon_e.x, mon_e.y,
                 dir, move_pulse, busy);
        chk("dir", mon_e.tag, 32'(dir), 32'(mon_e.dir));
        chk("move_pulse", mon_e.tag, 32'(move_pulse), 32'(mon_e.pulse));
        chk("busy", mon_e.tag, 32'(busy), 32'(mon_e.busy));
        last_dir  = mon_e.dir;
        last_busy = mon_e.busy;
      end
    end else begin
      chk("quiet_pulse", -1, 32'(move_pulse), 32'd0);
      chk("quiet_dir", -1, 32'(dir), 32'(last_dir));
      chk("quiet_busy", -1, 32'(busy), 32'(last_busy));
    end
    chk("pulse_back_to_back", -1, 32'(move_pulse && prev_pulse), 32'd0);
    prev_pulse = move_pulse;
  end

  // Stimulus helpers (entered and left on a falling edge)
  task automatic issue(input int x, input int y, input int gap);
    exp_t e;
    sample_valid = 1'b1;
    x_pos = 10'(x);
    y_pos = 10'(y);
    model_step(x, y, e);
    e.tag = txn_id; e.x = x; e.y = y;
    txn_id++;
    exp_q.push_back(e);
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic issue_n(input int x, input int y, input int n);
    for (int i = 0; i < n; i++) issue(x, y, $urandom_range(0, 2));
  endtask

  task automatic do_reset(input bit with_sample, input int x, input int y);
    exp_t e;
    rst = 1'b1;
    sample_valid = with_sample;
    x_pos = 10'(x);
    y_pos = 10'(y);
    model_reset();
    e.pulse = 1'b0; e.dir = 3'd4; e.busy = 1'b0; e.tag = txn_id; e.x = -1; e.y = -1;
    txn_id++;
    exp_q.push_back(e);
    @(negedge clk);
    rst = 1'b0;
    sample_valid = 1'b0;
  endtask

  function automatic int pick_pos();
    int edges [11] = '{0, 383, 384, 415, 416, 512, 608, 609, 640, 641, 1023};
    if ($urandom_range(0, 9) < 6) return edges[$urandom_range(0, 10)];
    return int'($urandom_range(0, 1023));
  endfunction

  initial begin
    #1_000_000;
    chk("timeout", -1, 32'd1, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    x_pos = '0;
    y_pos = '0;
    do_reset(1'b0, 0, 0);

    issue_n(512, 900, 3);            // up after three samples
    issue(512, 512, 1);
    issue_n(900, 512, 2);            // aborted by centre
    issue(512, 512, 1);
    issue_n(900, 512, 3);            // right, then hysteresis band and release
    issue(630, 512, 1);
    issue(600, 512, 1);
    for (int i = 0; i < 11; i++) issue(100, 512, 0);  // left with auto-repeat
    issue(512, 512, 2);
    issue_n(512, 100, 3);            // down, then other direction ignored
    issue_n(900, 512, 3);
    issue(900, 900, 1);
    issue(512, 512, 1);
    issue_n(512, 900, 2);            // reset on the third sample
    do_reset(1'b1, 512, 900);
    issue_n(512, 900, 3);
    issue(512, 512, 1);
    issue_n(383, 384, 3);            // dead-zone edges
    issue(384, 640, 1);
    issue(416, 608, 1);
    issue_n(641, 384, 4);
    issue(609, 416, 1);
    issue(512, 512, 1);

    for (int i = 0; i < 120; i++) begin
      int x, y, n;
      x = pick_pos();
      y = pick_pos();
      n = $urandom_range(1, 7);
      for (int j = 0; j < n; j++) issue(x, y, $urandom_range(0, 2));
      if ($urandom_range(0, 49) == 0) do_reset(1'($urandom_range(0, 1)), x, y);
    end

    repeat (4) @(negedge clk);
    chk("queue_drained", -1, 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
